biset_reply_collector: RTL and testbench
========================================

Name: biset_reply_collector

Overview:
- Master-side transaction tracker that sits directly downstream of the BiSet reply multiplexer.
- Accepts one command at a time from a client and emits a one-cycle launch pulse to the request driver.
- Waits for the merged reply from the multiplexer, with a timeout, then presents the captured reply or a timeout indication to the client on a valid/ready handshake.
- Counts replies that arrive while no transaction is outstanding ("stray" replies).

Parameters:
- TIMEOUT, 64, number of WAIT cycles without a valid reply before a timeout response is produced; legal range >= 1.
- STRAY_W, 8, width of the saturating stray-reply counter.

Ports:
- clk_i  input  1  clock, all logic on rising edge
- reset_n_i  input  1  synchronous active-low reset
- cmd_valid_i  input  1  client requests a transaction
- cmd_ready_o  output  1  block can accept a command (high only in IDLE)
- issue_o  output  1  one-cycle pulse: request driver launches the BiSet request
- reply_i  input  BiSet::BISET_REPLYLEN  merged reply (type BiSet::biSetReply); valid when BiSet::BiSetReplyValid(reply_i) is true
- rsp_valid_o  output  1  response available to client
- rsp_ready_i  input  1  client accepts response
- rsp_o  output  BiSet::BISET_REPLYLEN  captured reply; all-zero on timeout
- rsp_timeout_o  output  1  response is a timeout, qualified by rsp_valid_o
- busy_o  output  1  state != IDLE
- stray_cnt_o  output  STRAY_W  saturating count of stray replies

Behaviour:
- One clock, clk_i. reset_n_i is synchronous and active-low.
- Reset values:
  - state = IDLE
  - issue_o = 0, rsp_valid_o = 0, rsp_o = 0, rsp_timeout_o = 0
  - busy_o = 0, stray_cnt_o = 0, timeout counter = 0
  - cmd_ready_o = 1 from the first cycle after reset
- All outputs are registered except cmd_ready_o, which is (state == IDLE).
- States:
  - IDLE: cmd_valid_i & cmd_ready_o in cycle N -> in N+1: state = WAIT, issue_o = 1 for exactly one cycle, counter = 0.
  - WAIT:
    - A valid reply is sampled in every WAIT cycle, including the cycle issue_o is high.
    - Valid reply in cycle M -> in M+1: rsp_o = reply_i, rsp_timeout_o = 0, rsp_valid_o = 1, state = HOLD.
    - No valid reply and counter == TIMEOUT-1 -> in the next cycle: rsp_o = 0, rsp_timeout_o = 1, rsp_valid_o = 1, state = HOLD.
    - Otherwise counter increments.
    - With no reply, rsp_valid_o rises at N+TIMEOUT+1.
  - HOLD:
    - rsp_o, rsp_timeout_o and rsp_valid_o are held stable until rsp_valid_o & rsp_ready_i.
    - After that handshake: rsp_valid_o = 0, rsp_timeout_o = 0, state = IDLE.
    - rsp_o may retain its value after the handshake; it is don't-care while rsp_valid_o = 0.
- Latency: reply-to-response 1 cycle; minimum command-to-next-command 3 cycles (accept, WAIT with immediate reply, HOLD with ready already high).
- Replies are single-cycle pulses. Every clock cycle with a valid reply counts as one reply.
- Stray replies:
  - A valid reply in IDLE or HOLD increments stray_cnt_o by 1, saturating at 2^STRAY_W-1.
  - A stray reply never alters rsp_o or the state.
  - A valid reply in IDLE in the same cycle a command is accepted is stray.
  - A reply arriving after a timeout, in HOLD or IDLE, is stray.
- Simultaneous events:
  - Valid reply in the same cycle the counter hits TIMEOUT-1: the reply wins; no timeout is reported.
  - rsp_ready_i held high before HOLD is entered: the handshake completes in the first HOLD cycle.
- Reset mid-operation returns to IDLE from any state. The outstanding transaction is dropped with no response. stray_cnt_o clears.
- TIMEOUT = 1: timeout is reported when the single WAIT cycle has no reply.
- Counter width: $clog2(TIMEOUT+1) bits; it never wraps.

Test Plan:
- Basic reply: TIMEOUT=64; accept command at cycle 10; reply 0x…A5 valid at cycle 14 -> issue_o high only at cycle 11, rsp_valid_o=1 at 15 with rsp_o=reply and rsp_timeout_o=0; rsp_ready_i at 17 -> cmd_ready_o=1 at 18.
- Timeout: accept at 10, no reply -> rsp_valid_o=1 at cycle 75 with rsp_timeout_o=1 and rsp_o=0; late reply at 80 -> stray_cnt_o=1 at 81, rsp_o unchanged.
- Race: valid reply exactly on the last WAIT cycle (cycle 74 in the above setup) -> rsp_timeout_o=0, rsp_o=reply.
- Backpressure: hold rsp_ready_i=0 for 20 cycles in HOLD; cmd_valid_i=1 throughout -> response stable, cmd_ready_o=0, no second issue_o; replies during HOLD increment stray_cnt_o.
- Saturation: STRAY_W=2; 5 stray replies in IDLE -> stray_cnt_o reads 1, 2, 3, 3, 3.
- Reset mid-WAIT: accept command, pull reset_n_i low at 3rd WAIT cycle for 1 cycle -> all outputs at reset values next cycle, no rsp_valid_o ever asserted for the dropped command, new command is accepted normally.

Source files
------------

// File: rtl/biset_reply_collector.sv
// BiSet reply collector: tracks one outstanding BiSet request,
// captures the merged reply or a timeout, and counts stray replies.

package BiSet;
   localparam int BISET_REPLYLEN = 16;

   // MSB flags a valid reply, the low bits carry the payload.
   typedef logic [BISET_REPLYLEN-1:0] biSetReply;

   function automatic logic BiSetReplyValid(input biSetReply r);
      return r[BISET_REPLYLEN-1];
   endfunction
endpackage

module biset_reply_collector
   import BiSet::*;
#(
   parameter int TIMEOUT = 64,
   parameter int STRAY_W = 8
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic               cmd_valid_i,
   output logic               cmd_ready_o,
   output logic               issue_o,
   input  biSetReply          reply_i,
   output logic               rsp_valid_o,
   input  logic               rsp_ready_i,
   output biSetReply          rsp_o,
   output logic               rsp_timeout_o,
   output logic               busy_o,
   output logic [STRAY_W-1:0] stray_cnt_o
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t             state_q;
   state_t             state_d;
   logic [CW-1:0]      cnt_q;
   logic [CW-1:0]      cnt_d;
   logic               issue_d;
   logic               rsp_valid_d;
   biSetReply          rsp_d;
   logic               tmo_d;
   logic               stray_inc;
   logic [STRAY_W-1:0] stray_d;
   logic               rvalid;

   assign rvalid      = BiSetReplyValid(reply_i);
   assign cmd_ready_o = (state_q == IDLE);

   // Next-state, response capture and stray detection.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      issue_d     = 1'b0;
      rsp_valid_d = rsp_valid_o;
      rsp_d       = rsp_o;
      tmo_d       = rsp_timeout_o;
      stray_inc   = 1'b0;
      unique case (state_q)
         IDLE: begin
            stray_inc = rvalid;
            if (cmd_valid_i) begin
               state_d = WAIT;
               issue_d = 1'b1;
               cnt_d   = '0;
            end
         end
         WAIT: begin
            if (rvalid) begin
               rsp_d       = reply_i;
               tmo_d       = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = HOLD;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               rsp_d       = '0;
               tmo_d       = 1'b1;
               rsp_valid_d = 1'b1;
               state_d     = HOLD;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         HOLD: begin
            stray_inc = rvalid;
            if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               tmo_d       = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Saturating stray-reply count.
   always_comb begin
      stray_d = stray_cnt_o;
      if (stray_inc && !(&stray_cnt_o)) begin
         stray_d = stray_cnt_o + STRAY_W'(1);
      end
   end

   // State and registered outputs, synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         issue_o       <= 1'b0;
         rsp_valid_o   <= 1'b0;
         rsp_o         <= '0;
         rsp_timeout_o <= 1'b0;
         busy_o        <= 1'b0;
         stray_cnt_o   <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         issue_o       <= issue_d;
         rsp_valid_o   <= rsp_valid_d;
         rsp_o         <= rsp_d;
         rsp_timeout_o <= tmo_d;
         busy_o        <= (state_d != IDLE);
         stray_cnt_o   <= stray_d;
      end
   end

endmodule

// File: tb/tb_biset_reply_collector.sv
// Testbench for biset_reply_collector: table-driven transactions
// with a response scoreboard, plus multi-cycle corner sequences.

module tb_biset_reply_collector;
   import BiSet::*;

   localparam int TO = 64;

   typedef struct {
      int          dly;
      logic [14:0] d;
      logic        tmo;
      logic [15:0] rsp;
      int          lat;
   } vec_t;

   typedef struct {
      logic        tmo;
      logic [15:0] rsp;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid, cmd_ready, issue;
   logic       rsp_valid, rsp_ready, rsp_timeout, busy;
   biSetReply  reply, rsp;
   logic [7:0] stray;

   logic       b_cmd_valid, b_cmd_ready, b_issue;
   logic       b_rsp_valid, b_rsp_ready, b_rsp_timeout, b_busy;
   biSetReply  b_reply, b_rsp;
   logic [1:0] b_stray;

   int   n_run = 0;
   int   n_fail = 0;
   exp_t sb[$];

   biset_reply_collector #(.TIMEOUT(TO), .STRAY_W(8)) dut_a (
      .clk_i(clk), .reset_n_i(rst_n),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .issue_o(issue), .reply_i(reply),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_o(rsp), .rsp_timeout_o(rsp_timeout),
      .busy_o(busy), .stray_cnt_o(stray)
   );

   biset_reply_collector #(.TIMEOUT(1), .STRAY_W(2)) dut_b (
      .clk_i(clk), .reset_n_i(rst_n),
      .cmd_valid_i(b_cmd_valid), .cmd_ready_o(b_cmd_ready),
      .issue_o(b_issue), .reply_i(b_reply),
      .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
      .rsp_o(b_rsp), .rsp_timeout_o(b_rsp_timeout),
      .busy_o(b_busy), .stray_cnt_o(b_stray)
   );

   always #5 clk = ~clk;

   function automatic biSetReply mk(input logic [14:0] d);
      return {1'b1, d};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] a,
                      input logic [31:0] e);
      n_run++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, a, e);
      end
   endtask

   task automatic pop_chk();
      exp_t e;
      if (sb.size() == 0) begin
         n_run++;
         n_fail++;
         $display("FAIL sb_empty: got response expected none");
      end else begin
         e = sb.pop_front();
         chk("rsp_timeout", 32'(rsp_timeout), 32'(e.tmo));
         chk("rsp_data", 32'(rsp), 32'(e.rsp));
      end
   endtask

   task automatic hsk();
      chk("rsp_valid_hold", 32'(rsp_valid), 32'd1);
      pop_chk();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("rsp_valid_clr", 32'(rsp_valid), 32'd0);
      chk("cmd_ready_back", 32'(cmd_ready), 32'd1);
      chk("busy_clr", 32'(busy), 32'd0);
   endtask

   task automatic run_txn(input int dly, input logic [14:0] d,
                          input logic etmo, input logic [15:0] ersp,
                          input int elat);
      int   lat;
      logic extra;
      exp_t e;
      lat   = -1;
      extra = 1'b0;
      chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
      e.tmo = etmo;
      e.rsp = ersp;
      sb.push_back(e);
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      chk("issue_pulse", 32'(issue), 32'd1);
      chk("busy_set", 32'(busy), 32'd1);
      for (int k = 0; k < TO + 4; k++) begin
         reply = (k == dly) ? mk(d) : '0;
         tick();
         reply = '0;
         if (issue) extra = 1'b1;
         if (rsp_valid) begin
            lat = k;
            break;
         end
      end
      chk("issue_once", 32'(extra), 32'd0);
      chk("latency", 32'(lat), 32'(elat));
   endtask

   vec_t vecs[5];
   int   sat_exp[5];

   initial begin
      int   s0;
      logic bad;

      vecs[0] = '{3,  15'h00A5, 1'b0, 16'h80A5, 3};
      vecs[1] = '{0,  15'h1234, 1'b0, 16'h9234, 0};
      vecs[2] = '{10, 15'h0001, 1'b0, 16'h8001, 10};
      vecs[3] = '{63, 15'h7FFF, 1'b0, 16'hFFFF, 63};
      vecs[4] = '{-1, 15'h0000, 1'b1, 16'h0000, 63};
      sat_exp = '{1, 2, 3, 3, 3};

      rst_n = 1'b0;
      cmd_valid = 1'b0; rsp_ready = 1'b0; reply = '0;
      b_cmd_valid = 1'b0; b_rsp_ready = 1'b0; b_reply = '0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_issue", 32'(issue), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp", 32'(rsp), 32'd0);
      chk("rst_timeout", 32'(rsp_timeout), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_stray", 32'(stray), 32'd0);

      for (int i = 0; i < 5; i++) begin
         run_txn(vecs[i].dly, vecs[i].d, vecs[i].tmo,
                 vecs[i].rsp, vecs[i].lat);
         tick();
         hsk();
      end

      // timeout, then a late reply in HOLD is stray
      run_txn(-1, 15'h0, 1'b1, 16'h0000, TO - 1);
      s0 = int'(stray);
      repeat (4) tick();
      reply = mk(15'h0055);
      tick();
      reply = '0;
      chk("late_stray", 32'(stray), 32'(s0 + 1));
      chk("late_rsp_kept", 32'(rsp), 32'd0);
      chk("late_tmo_kept", 32'(rsp_timeout), 32'd1);
      hsk();

      // backpressure in HOLD with cmd_valid held high
      run_txn(5, 15'h0A5A, 1'b0, 16'h8A5A, 5);
      s0 = int'(stray);
      bad = 1'b0;
      cmd_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         reply = (i % 6 == 2) ? mk(15'(i)) : '0;
         tick();
         reply = '0;
         if (rsp !== 16'h8A5A || rsp_valid !== 1'b1 ||
             cmd_ready !== 1'b0 || issue !== 1'b0 ||
             rsp_timeout !== 1'b0)
            bad = 1'b1;
      end
      cmd_valid = 1'b0;
      chk("bp_stable", 32'(bad), 32'd0);
      chk("bp_stray", 32'(stray), 32'(s0 + 3));
      hsk();

      // reply in IDLE on the accepting cycle is stray
      s0 = int'(stray);
      sb.push_back('{1'b0, 16'h8321});
      cmd_valid = 1'b1;
      reply = mk(15'h7777);
      tick();
      cmd_valid = 1'b0;
      reply = mk(15'h0321);
      chk("accept_stray", 32'(stray), 32'(s0 + 1));
      chk("accept_issue", 32'(issue), 32'd1);
      tick();
      reply = '0;
      chk("accept_rsp", 32'(rsp_valid), 32'd1);
      hsk();

      // ready high before HOLD: three-cycle command spacing
      rsp_ready = 1'b1;
      sb.push_back('{1'b0, 16'h80BB});
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      reply = mk(15'h00BB);
      tick();
      reply = '0;
      chk("fast_valid", 32'(rsp_valid), 32'd1);
      pop_chk();
      cmd_valid = 1'b1;
      tick();
      chk("fast_done", 32'(rsp_valid), 32'd0);
      chk("fast_ready", 32'(cmd_ready), 32'd1);
      sb.push_back('{1'b0, 16'h80CC});
      tick();
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      chk("fast_issue", 32'(issue), 32'd1);
      reply = mk(15'h00CC);
      tick();
      reply = '0;
      hsk();

      // reset in the third WAIT cycle drops the transaction
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("mrst_ready", 32'(cmd_ready), 32'd1);
      chk("mrst_issue", 32'(issue), 32'd0);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_stray", 32'(stray), 32'd0);
      chk("mrst_valid", 32'(rsp_valid), 32'd0);
      bad = 1'b0;
      for (int i = 0; i < TO + 6; i++) begin
         tick();
         if (rsp_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      end
      chk("mrst_no_rsp", 32'(bad), 32'd0);
      run_txn(2, 15'h0042, 1'b0, 16'h8042, 2);
      tick();
      hsk();

      // STRAY_W=2 saturation in IDLE
      for (int i = 0; i < 5; i++) begin
         b_reply = mk(15'(i + 1));
         tick();
         b_reply = '0;
         chk("sat_cnt", 32'(b_stray), 32'(sat_exp[i]));
      end

      // TIMEOUT=1: single empty WAIT cycle times out
      b_cmd_valid = 1'b1;
      tick();
      b_cmd_valid = 1'b0;
      chk("t1_issue", 32'(b_issue), 32'd1);
      tick();
      chk("t1_valid", 32'(b_rsp_valid), 32'd1);
      chk("t1_tmo", 32'(b_rsp_timeout), 32'd1);
      chk("t1_rsp", 32'(b_rsp), 32'd0);
      b_rsp_ready = 1'b1;
      tick();
      b_rsp_ready = 1'b0;
      chk("t1_clr", 32'(b_rsp_valid), 32'd0);

      // TIMEOUT=1: reply on the single WAIT cycle wins
      b_cmd_valid = 1'b1;
      tick();
      b_cmd_valid = 1'b0;
      b_reply = mk(15'h001C);
      tick();
      b_reply = '0;
      chk("t1r_valid", 32'(b_rsp_valid), 32'd1);
      chk("t1r_tmo", 32'(b_rsp_timeout), 32'd0);
      chk("t1r_rsp", 32'(b_rsp), 32'h801C);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
